// File: rtl/y86_seq_core_if.sv
// y86_seq_core_if
//   Bundles the signals between the fetch/memory side of the sequential
//   Y86-64 datapath and the decode/execute/writeback/PC core.
//
//   Fetch/memory -> core : icode, ifun, rA, rB, valC, valP, valM, dbg_sel
//   Core -> memory/debug : valA, valB, valE, cnd, zf, sf, of, pc, pc_next,
//                          dbg_data
//
//   master : the environment (fetch + data memory + debug host)
//   slave  : y86_seq_core
interface y86_seq_core_if;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] valM;

    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valE;
    logic        cnd;
    logic        zf;
    logic        sf;
    logic        of;
    logic [63:0] pc;
    logic [63:0] pc_next;

    logic [3:0]  dbg_sel;
    logic [63:0] dbg_data;

    modport master (
        output icode, ifun, rA, rB, valC, valP, valM, dbg_sel,
        input  valA, valB, valE, cnd, zf, sf, of, pc, pc_next, dbg_data
    );

    modport slave (
        input  icode, ifun, rA, rB, valC, valP, valM, dbg_sel,
        output valA, valB, valE, cnd, zf, sf, of, pc, pc_next, dbg_data
    );
endinterface

// File: rtl/y86_seq_core.sv
// y86_seq_core
//   Decode/writeback, execute and PC-update stage of the sequential
//   Y86-64 processor. Holds the 15-entry register file, the condition-code
//   register (ZF/SF/OF) and the architectural PC.
//
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : y86_seq_core_if.slave
//              in : icode, ifun, rA, rB, valC, valP, valM, dbg_sel
//              out: valA, valB, valE, cnd, zf, sf, of, pc, pc_next, dbg_data
//
//   Parameters:
//     RESET_PC   : PC loaded on reset
//     STACK_INIT : %rsp (register 4) loaded on reset
module y86_seq_core #(
    parameter logic [63:0] RESET_PC   = 64'd1,
    parameter logic [63:0] STACK_INIT = 64'd128
) (
    input  logic             clk,
    input  logic             rst_n,
    y86_seq_core_if.slave    bus
);

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] R_RSP   = 4'h4;
    localparam logic [3:0] R_NONE  = 4'hF;

    localparam logic [3:0] F_ADD   = 4'h0;
    localparam logic [3:0] F_SUB   = 4'h1;
    localparam logic [3:0] F_AND   = 4'h2;
    localparam logic [3:0] F_XOR   = 4'h3;

    // Architectural state
    logic [63:0] regs_q [0:14];
    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic        zf_q, sf_q, of_q;
    logic        zf_d, sf_d, of_d;

    // Decode / execute intermediates
    logic [3:0]  src_a, src_b;
    logic [3:0]  dst_e, dst_m;
    logic [63:0] val_a, val_b, val_e;
    logic        of_new;
    logic        cc_we;
    logic        cnd;

    // Signed overflow of valB + valA, judged from the three sign bits.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic se);
        return (sa == sb) && (se != sb);
    endfunction

    // Signed overflow of valB - valA, judged from the three sign bits.
    function automatic logic sub_ovf(input logic sa, input logic sb, input logic se);
        return (sa != sb) && (se != sb);
    endfunction

    // Branch / conditional-move condition from the stored flags.
    function automatic logic cond_eval(input logic [3:0] fn, input logic z,
                                       input logic s, input logic o);
        logic lt;
        lt = s ^ o;
        case (fn)
            4'h0:    return 1'b1;
            4'h1:    return lt | z;
            4'h2:    return lt;
            4'h3:    return z;
            4'h4:    return ~z;
            4'h5:    return ~lt;
            4'h6:    return ~lt & ~z;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------------------------------------------------------
    // Decode: choose source registers and read the register file
    // ---------------------------------------------------------------
    always_comb begin
        src_a = R_NONE;
        src_b = R_NONE;
        case (bus.icode)
            I_CMOV, I_RMMOV, I_OP, I_PUSH: src_a = bus.rA;
            I_RET, I_POP:                  src_a = R_RSP;
            default:                       src_a = R_NONE;
        endcase
        case (bus.icode)
            I_RMMOV, I_MRMOV, I_OP:        src_b = bus.rB;
            I_CALL, I_RET, I_PUSH, I_POP:  src_b = R_RSP;
            default:                       src_b = R_NONE;
        endcase
    end

    // Id 0xF has no storage behind it and always reads as zero.
    assign val_a = (src_a == R_NONE) ? 64'd0 : regs_q[src_a];
    assign val_b = (src_b == R_NONE) ? 64'd0 : regs_q[src_b];

    // Conditions look at the flags left by the previous OPq, not this one.
    assign cnd = ((bus.icode == I_CMOV) || (bus.icode == I_JXX))
               ? cond_eval(bus.ifun, zf_q, sf_q, of_q) : 1'b0;

    // ---------------------------------------------------------------
    // Execute: ALU and condition-code next state
    // ---------------------------------------------------------------
    always_comb begin
        val_e  = 64'd0;
        of_new = 1'b0;
        cc_we  = 1'b0;
        case (bus.icode)
            I_CMOV:           val_e = val_a;
            I_IRMOV:          val_e = bus.valC;
            I_RMMOV, I_MRMOV: val_e = val_b + bus.valC;
            I_OP: begin
                case (bus.ifun)
                    F_ADD: begin
                        val_e  = val_b + val_a;
                        of_new = add_ovf(val_a[63], val_b[63], val_e[63]);
                        cc_we  = 1'b1;
                    end
                    F_SUB: begin
                        val_e  = val_b - val_a;
                        of_new = sub_ovf(val_a[63], val_b[63], val_e[63]);
                        cc_we  = 1'b1;
                    end
                    F_AND: begin
                        val_e  = val_b & val_a;
                        cc_we  = 1'b1;
                    end
                    F_XOR: begin
                        val_e  = val_b ^ val_a;
                        cc_we  = 1'b1;
                    end
                    default: val_e = 64'd0;
                endcase
            end
            I_CALL, I_PUSH:   val_e = val_b - 64'd8;
            I_RET, I_POP:     val_e = val_b + 64'd8;
            default:          val_e = 64'd0;
        endcase

        zf_d = cc_we ? (val_e == 64'd0) : zf_q;
        sf_d = cc_we ? val_e[63]        : sf_q;
        of_d = cc_we ? of_new           : of_q;
    end

    // ---------------------------------------------------------------
    // Writeback destinations and next PC
    // ---------------------------------------------------------------
    always_comb begin
        dst_e = R_NONE;
        dst_m = R_NONE;
        case (bus.icode)
            I_IRMOV, I_OP:                 dst_e = bus.rB;
            I_CMOV:                        dst_e = cnd ? bus.rB : R_NONE;
            I_CALL, I_RET, I_PUSH, I_POP:  dst_e = R_RSP;
            default:                       dst_e = R_NONE;
        endcase
        case (bus.icode)
            I_MRMOV, I_POP:                dst_m = bus.rA;
            default:                       dst_m = R_NONE;
        endcase
    end

    always_comb begin
        pc_d = bus.valP;
        case (bus.icode)
            I_JXX:  pc_d = cnd ? bus.valC : bus.valP;
            I_CALL: pc_d = bus.valC;
            I_RET:  pc_d = bus.valM;
            I_NOP, I_CMOV, I_IRMOV, I_RMMOV, I_MRMOV, I_OP, I_PUSH, I_POP:
                    pc_d = bus.valP;
            // halt and undefined codes freeze the PC
            default: pc_d = pc_q;
        endcase
    end

    // ---------------------------------------------------------------
    // State update
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= (i == 4) ? STACK_INIT : 64'd0;
            end
            pc_q <= RESET_PC;
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
            if (dst_e != R_NONE) begin
                regs_q[dst_e] <= val_e;
            end
            // Port M is written last so it wins a collision (popq %rsp).
            if (dst_m != R_NONE) begin
                regs_q[dst_m] <= bus.valM;
            end
        end
    end

    assign bus.valA     = val_a;
    assign bus.valB     = val_b;
    assign bus.valE     = val_e;
    assign bus.cnd      = cnd;
    assign bus.zf       = zf_q;
    assign bus.sf       = sf_q;
    assign bus.of       = of_q;
    assign bus.pc       = pc_q;
    assign bus.pc_next  = pc_d;
    assign bus.dbg_data = (bus.dbg_sel == R_NONE) ? 64'd0 : regs_q[bus.dbg_sel];

endmodule

// File: tb/tb_y86_seq_core.sv
module tb_y86_seq_core;

    logic clk = 1'b0;
    logic rst_n;
    always #25 clk = ~clk;

    y86_seq_core_if bus();

    y86_seq_core #(
        .RESET_PC   (64'd1),
        .STACK_INIT (64'd128)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference architectural state; entry 15 is the "no register" slot, stays 0.
    logic [63:0] m_reg [16];
    logic [63:0] m_pc;
    logic        m_zf, m_sf, m_of;

    // Pending effects of the instruction currently presented
    logic [3:0]  p_de, p_dm;
    logic [63:0] p_ve, p_vm, p_pn;
    logic        p_cc, p_z, p_s, p_o;

    typedef struct {
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] vc, vp, vm;
        logic [63:0] x_e;
        logic        x_cnd;
        logic [63:0] x_pn;
        logic [3:0]  x_reg;
        logic [63:0] x_regv;
        logic [63:0] x_pc;
        logic [2:0]  x_zso;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 64'd0;
        m_reg[4] = 64'd128;
        m_pc = 64'd1;
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    endtask

    function automatic logic [63:0] rd(input logic [3:0] id);
        return m_reg[id];
    endfunction

    function automatic logic cond_ok(input logic [3:0] f, input logic z, input logic s, input logic o);
        logic less;
        less = (s != o);
        case (f)
            4'd0: return 1'b1;
            4'd1: return less || z;
            4'd2: return less;
            4'd3: return z;
            4'd4: return !z;
            4'd5: return !less;
            4'd6: return !less && !z;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level semantics of one Y86 step.
    task automatic model_eval(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc, vp, vm,
                              output logic [63:0] eA, eB, eE, output logic eC, output logic [63:0] ePn);
        logic [64:0] w;
        eA = 0; eB = 0; eE = 0; eC = 0; ePn = vp;
        p_de = 4'hF; p_dm = 4'hF; p_cc = 0; p_o = 0;
        case (ic)
            4'h1: ;
            4'h2: begin eA = rd(ra); eC = cond_ok(fn, m_zf, m_sf, m_of); eE = eA; if (eC) p_de = rb; end
            4'h3: begin eE = vc; p_de = rb; end
            4'h4: begin eA = rd(ra); eB = rd(rb); eE = eB + vc; end
            4'h5: begin eB = rd(rb); eE = eB + vc; p_dm = ra; end
            4'h6: begin
                eA = rd(ra); eB = rd(rb); p_de = rb; p_cc = 1;
                if (fn == 0) begin w = {eB[63], eB} + {eA[63], eA}; eE = w[63:0]; p_o = (w[64] != w[63]); end
                else if (fn == 1) begin w = {eB[63], eB} - {eA[63], eA}; eE = w[63:0]; p_o = (w[64] != w[63]); end
                else if (fn == 2) eE = eB & eA;
                else eE = eB ^ eA;
            end
            4'h7: begin eC = cond_ok(fn, m_zf, m_sf, m_of); if (eC) ePn = vc; end
            4'h8: begin eB = rd(4); eE = eB - 8; p_de = 4; ePn = vc; end
            4'h9: begin eA = rd(4); eB = rd(4); eE = eB + 8; p_de = 4; ePn = vm; end
            4'hA: begin eA = rd(ra); eB = rd(4); eE = eB - 8; p_de = 4; end
            4'hB: begin eA = rd(4); eB = rd(4); eE = eB + 8; p_de = 4; p_dm = ra; end
            default: ePn = m_pc;
        endcase
        p_ve = eE; p_vm = vm; p_pn = ePn;
        p_z = (eE == 0); p_s = eE[63];
    endtask

    task automatic model_commit();
        if (p_de != 4'hF) m_reg[p_de] = p_ve;
        if (p_dm != 4'hF) m_reg[p_dm] = p_vm;
        if (p_cc) begin m_zf = p_z; m_sf = p_s; m_of = p_o; end
        m_pc = p_pn;
    endtask

    task automatic check_state(input string tag);
        check({tag, " pc"}, bus.pc, m_pc);
        check({tag, " zf"}, 64'(bus.zf), 64'(m_zf));
        check({tag, " sf"}, 64'(bus.sf), 64'(m_sf));
        check({tag, " of"}, 64'(bus.of), 64'(m_of));
        for (int s = 0; s < 16; s++) begin
            bus.dbg_sel = 4'(s);
            #1;
            check($sformatf("%s reg%0d", tag, s), bus.dbg_data, m_reg[s]);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc, vp, vm,
                        output logic [63:0] o_e, output logic o_cnd, output logic [63:0] o_pn);
        logic [63:0] eA, eB, eE, ePn;
        logic eC;
        @(negedge clk);
        bus.icode = ic; bus.ifun = fn; bus.rA = ra; bus.rB = rb;
        bus.valC = vc; bus.valP = vp; bus.valM = vm;
        #1;
        model_eval(ic, fn, ra, rb, vc, vp, vm, eA, eB, eE, eC, ePn);
        check({tag, " valA"}, bus.valA, eA);
        check({tag, " valB"}, bus.valB, eB);
        check({tag, " valE"}, bus.valE, eE);
        check({tag, " cnd"}, 64'(bus.cnd), 64'(eC));
        check({tag, " pc_next"}, bus.pc_next, ePn);
        o_e = bus.valE; o_cnd = bus.cnd; o_pn = bus.pc_next;
        @(posedge clk);
        #1;
        model_commit();
        check_state(tag);
    endtask

    function automatic vec_t mk(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc, vp, vm, x_e,
                                input logic x_cnd, input logic [63:0] x_pn, input logic [3:0] x_reg,
                                input logic [63:0] x_regv, x_pc, input logic [2:0] x_zso);
        vec_t v;
        v.ic = ic; v.fn = fn; v.ra = ra; v.rb = rb; v.vc = vc; v.vp = vp; v.vm = vm;
        v.x_e = x_e; v.x_cnd = x_cnd; v.x_pn = x_pn; v.x_reg = x_reg; v.x_regv = x_regv;
        v.x_pc = x_pc; v.x_zso = x_zso;
        return v;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0: return 64'd0;
            1: return 64'($urandom_range(0, 64));
            2: return {$urandom, $urandom};
            default: return 64'h8000_0000_0000_0000 | 64'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] o_e, o_pn;
        logic o_c;
        logic [3:0] ic, fn;
        int r;

        rst_n = 1'b0;
        bus.icode = 0; bus.ifun = 0; bus.rA = 4'hF; bus.rB = 4'hF;
        bus.valC = 0; bus.valP = 0; bus.valM = 0; bus.dbg_sel = 4'hF;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("reset");

        // Directed program
        tbl.push_back(mk(4'h3,0,4'hF,4'h2,120,16,0, 120,0,16, 4'h2,120,16, 3'b100));
        tbl.push_back(mk(4'h3,0,4'hF,4'h1,100,26,0, 100,0,26, 4'h1,100,26, 3'b100));
        tbl.push_back(mk(4'h3,0,4'hF,4'h5,4,36,0,   4,0,36,   4'h5,4,36,   3'b100));
        tbl.push_back(mk(4'h3,0,4'hF,4'hA,7,46,0,   7,0,46,   4'hA,7,46,   3'b100));
        tbl.push_back(mk(4'h6,0,4'h1,4'h5,0,48,0,   104,0,48, 4'h5,104,48, 3'b000));
        tbl.push_back(mk(4'h2,6,4'hA,4'hB,0,50,0,   7,1,50,   4'hB,7,50,   3'b000));
        tbl.push_back(mk(4'h3,0,4'hF,4'h1,1,60,0,   1,0,60,   4'h1,1,60,   3'b000));
        tbl.push_back(mk(4'h3,0,4'hF,4'h2,64'h8000_0000_0000_0000,70,0, 64'h8000_0000_0000_0000,0,70,
                         4'h2,64'h8000_0000_0000_0000,70, 3'b000));
        tbl.push_back(mk(4'h6,1,4'h1,4'h2,0,72,0, 64'h7FFF_FFFF_FFFF_FFFF,0,72,
                         4'h2,64'h7FFF_FFFF_FFFF_FFFF,72, 3'b001));
        tbl.push_back(mk(4'h7,2,4'hF,4'hF,55,81,0,  0,1,55,   4'h4,128,55, 3'b001));
        tbl.push_back(mk(4'h6,3,4'h5,4'h5,0,57,0,   0,0,57,   4'h5,0,57,   3'b100));
        tbl.push_back(mk(4'h7,4,4'hF,4'hF,200,66,0, 0,0,66,   4'h4,128,66, 3'b100));
        tbl.push_back(mk(4'h8,0,4'hF,4'hF,55,75,0,  120,0,55, 4'h4,120,55, 3'b100));
        tbl.push_back(mk(4'h9,0,4'hF,4'hF,0,56,47,  128,0,47, 4'h4,128,47, 3'b100));
        tbl.push_back(mk(4'hA,0,4'h1,4'hF,0,49,0,   120,0,49, 4'h4,120,49, 3'b100));
        tbl.push_back(mk(4'hB,0,4'h4,4'hF,0,51,64'h99, 128,0,51, 4'h4,64'h99,51, 3'b100));
        tbl.push_back(mk(4'h4,0,4'h1,4'h5,16,60,0,  16,0,60,  4'h5,0,60,   3'b100));
        tbl.push_back(mk(4'h5,0,4'h3,4'h2,8,70,64'h1234, 64'h8000_0000_0000_0007,0,70,
                         4'h3,64'h1234,70, 3'b100));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(4'h0,0,4'h1,4'h2,5,99,7, 0,0,70, 4'h4,64'h99,70, 3'b100));
        tbl.push_back(mk(4'hC,0,4'h1,4'h2,5,99,7,   0,0,70,   4'h3,64'h1234,70, 3'b100));

        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(t, tbl[i].ic, tbl[i].fn, tbl[i].ra, tbl[i].rb, tbl[i].vc, tbl[i].vp, tbl[i].vm,
                 o_e, o_c, o_pn);
            check({t, " tbl valE"}, o_e, tbl[i].x_e);
            check({t, " tbl cnd"}, 64'(o_c), 64'(tbl[i].x_cnd));
            check({t, " tbl pc_next"}, o_pn, tbl[i].x_pn);
            bus.dbg_sel = tbl[i].x_reg;
            #1;
            check({t, " tbl reg"}, bus.dbg_data, tbl[i].x_regv);
            check({t, " tbl pc"}, bus.pc, tbl[i].x_pc);
            check({t, " tbl flags"}, 64'({bus.zf, bus.sf, bus.of}), 64'(tbl[i].x_zso));
        end

        // Asynchronous reset in the middle of a cycle with a write pending
        @(negedge clk);
        bus.icode = 4'h3; bus.ifun = 0; bus.rA = 4'hF; bus.rB = 4'h3;
        bus.valC = 64'd5; bus.valP = 64'd77; bus.valM = 0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async pc", bus.pc, 64'd1);
        check("async zf", 64'(bus.zf), 64'd1);
        @(posedge clk);
        #1;
        model_reset();
        check_state("rst_hold");
        bus.icode = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random instruction stream against the reference model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 3)      ic = 4'h0;
            else if (r < 5) ic = 4'($urandom_range(12, 15));
            else            ic = 4'($urandom_range(1, 11));
            fn = (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 7));
            step($sformatf("rnd%0d", n), ic, fn, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 rnd64(), {$urandom, $urandom}, rnd64(), o_e, o_c, o_pn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
